spi_bitrev_slave: RTL and testbench

- Parametrised SPI slave test peripheral for SoC SPI-master bring-up.
- Receives a WIDTH-bit word MSB-first on mosi, then returns the bit-reversed word MSB-first on miso.
- Holding ss low allows back-to-back words (burst).
- SPI pins are oversampled in the system clock domain; all four SPI modes are selectable by parameter.
- Adds a receive-strobe side interface and abort detection.

---
 rtl/spi_bitrev_slave_if.sv | 34 +++
 rtl/spi_bitrev_slave.sv | 214 +++++++++++++++++++++
 tb/tb_spi_bitrev_slave.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bitrev_slave_if.sv
// rtl/spi_bitrev_slave_if.sv - SPI pin and receive-side bundle for spi_bitrev_slave
//
// Signals:
//   sck, ss, mosi   SPI pins driven by the master (asynchronous to the system clock)
//   miso            slave-out data
//   rx_valid        one-cycle pulse per received word
//   rx_data         last received word, held between pulses
//   word_cnt        completed TX words since reset (wraps)
//   abort           sticky: ss rose mid-word
//   busy            slave FSM is not idle
interface spi_bitrev_slave_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             sck;
    logic             ss;
    logic             mosi;
    logic             miso;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic [CNT_W-1:0] word_cnt;
    logic             abort;
    logic             busy;

    modport slave (
        input  sck, ss, mosi,
        output miso, rx_valid, rx_data, word_cnt, abort, busy
    );

    modport master (
        output sck, ss, mosi,
        input  miso, rx_valid, rx_data, word_cnt, abort, busy
    );
endinterface

// File: rtl/spi_bitrev_slave.sv
// rtl/spi_bitrev_slave.sv - oversampled SPI slave that echoes each received word bit-reversed
//
// Receives a WIDTH-bit word MSB-first on mosi, then returns the bit-reversed
// word MSB-first on miso. Holding ss low chains words back to back.
// Optional macro SPI_BITREV_PARITY_EN appends an even-parity bit to each TX word.
//
// Ports:
//   clock_i    system clock, at least 4x the sck frequency
//   reset_n_i  asynchronous active-low reset
//   bus        spi_bitrev_slave_if.slave (SPI pins, receive strobe, counters, status)
module spi_bitrev_slave #(
    parameter int WIDTH = 8,
    parameter int CPOL  = 0,
    parameter int CPHA  = 0,
    parameter int CNT_W = 16
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    spi_bitrev_slave_if.slave  bus
);

`ifdef SPI_BITREV_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int TX_BITS = WIDTH + PAR_BITS;
    localparam int BC_W    = $clog2(TX_BITS + 1);
    localparam logic POL   = (CPOL != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RX   = 2'd1,
        S_TX   = 2'd2
    } state_e;

    state_e state_q, state_d;

    // [0],[1] form the synchroniser; [2] is the delayed copy for edge detection
    logic [2:0] sck_sr_q;
    logic [2:0] ss_sr_q;
    logic [1:0] mosi_sr_q;

    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [TX_BITS-1:0] tx_q, tx_d;
    logic               miso_q, miso_d;
    logic               rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               abort_q, abort_d;

    logic sck_s, sck_p, ss_s, ss_fall, mosi_s;
    logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic rx_last, tx_last;
    logic [WIDTH-1:0] rx_word;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    assign sck_s   = sck_sr_q[1];
    assign sck_p   = sck_sr_q[2];
    assign ss_s    = ss_sr_q[1];
    assign ss_fall = ~ss_sr_q[1] & ss_sr_q[2];
    assign mosi_s  = mosi_sr_q[1];

    assign sck_rise    = sck_s & ~sck_p;
    assign sck_fall    = ~sck_s & sck_p;
    // Leading edge is sck leaving its idle (CPOL) level
    assign lead_edge   = POL ? sck_fall : sck_rise;
    assign trail_edge  = POL ? sck_rise : sck_fall;
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

    assign rx_last = (bit_cnt_q == BC_W'(WIDTH - 1));
    assign tx_last = (bit_cnt_q == BC_W'(TX_BITS - 1));
    assign rx_word = {shreg_q[WIDTH-2:0], mosi_s};

    // Input synchronisers; sck resets to its idle level so no false edge leaves reset
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sck_sr_q  <= {3{POL}};
            ss_sr_q   <= 3'b111;
            mosi_sr_q <= 2'b00;
        end else begin
            sck_sr_q  <= {sck_sr_q[1:0], bus.sck};
            ss_sr_q   <= {ss_sr_q[1:0], bus.ss};
            mosi_sr_q <= {mosi_sr_q[0], bus.mosi};
        end
    end

    // State register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ss deassert overrides everything, then sck edges
    always_comb begin
        state_d = state_q;
        if (ss_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (ss_fall) state_d = S_RX;
                S_RX:    if (sample_edge && rx_last) state_d = S_TX;
                S_TX:    if (sample_edge && tx_last) state_d = S_RX;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath / output next values
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        word_cnt_d = word_cnt_q;
        abort_d    = abort_q;
        if (ss_s) begin
            // A TX phase with zero bits sampled still counts as an interrupted word
            if ((bit_cnt_q != '0) || (state_q == S_TX)) begin
                abort_d = 1'b1;
            end
            bit_cnt_d = '0;
            shreg_d   = '0;
            miso_d    = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ss_fall) begin
                        abort_d = 1'b0;
                    end
                end
                S_RX: begin
                    if (shift_edge) begin
                        miso_d = 1'b1;
                    end
                    if (sample_edge) begin
                        shreg_d = rx_word;
                        if (rx_last) begin
                            bit_cnt_d  = '0;
                            rx_valid_d = 1'b1;
                            rx_data_d  = rx_word;
`ifdef SPI_BITREV_PARITY_EN
                            tx_d = {bitrev(rx_word), ^rx_word};
`else
                            tx_d = bitrev(rx_word);
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_TX: begin
                    if (shift_edge) begin
                        miso_d = tx_q[TX_BITS-1];
                        tx_d   = {tx_q[TX_BITS-2:0], 1'b0};
                    end
                    if (sample_edge) begin
                        if (tx_last) begin
                            bit_cnt_d  = '0;
                            word_cnt_d = word_cnt_q + 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= '0;
            miso_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            word_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            word_cnt_q <= word_cnt_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.miso     = miso_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.word_cnt = word_cnt_q;
    assign bus.abort    = abort_q;
    assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// tb/tb_spi_bitrev_slave.sv - self-checking bench for spi_bitrev_slave across SPI modes and widths
module tb_spi_bitrev_slave;

`ifdef SPI_BITREV_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NI   = 5;
    localparam int HALF = 4;

    typedef struct {
        int          inst;
        logic [31:0] word;
        logic [31:0] exp_rd;
        bit          raise;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NI-1:0] sck_v  = 5'b01100;
    logic [NI-1:0] ss_v   = 5'b11111;
    logic [NI-1:0] mosi_v = 5'b00000;
    wire  [NI-1:0] miso_v, rxv_v, abort_v, busy_v;
    wire  [31:0]   rxd_v [NI];
    wire  [15:0]   wc_v  [NI];

    int width_of [NI] = '{8, 8, 8, 8, 16};
    int cpol_of  [NI] = '{0, 0, 1, 1, 0};
    int cpha_of  [NI] = '{0, 1, 0, 1, 0};
    int cmod_of  [NI] = '{65536, 65536, 65536, 4, 65536};
    int exp_cnt  [NI] = '{0, 0, 0, 0, 0};
    int rxv_cnt  [NI] = '{0, 0, 0, 0, 0};

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W  = (g == 4) ? 16 : 8;
        localparam int PL = (g == 2 || g == 3) ? 1 : 0;
        localparam int PH = (g == 1 || g == 3) ? 1 : 0;
        localparam int CW = (g == 3) ? 2 : 16;
        spi_bitrev_slave_if #(.WIDTH(W), .CNT_W(CW)) bus ();
        assign bus.sck  = sck_v[g];
        assign bus.ss   = ss_v[g];
        assign bus.mosi = mosi_v[g];
        spi_bitrev_slave #(.WIDTH(W), .CPOL(PL), .CPHA(PH), .CNT_W(CW)) dut (
            .clock_i   (clk),
            .reset_n_i (rst_n),
            .bus       (bus)
        );
        assign miso_v[g]  = bus.miso;
        assign rxv_v[g]   = bus.rx_valid;
        assign abort_v[g] = bus.abort;
        assign busy_v[g]  = bus.busy;
        assign rxd_v[g]   = 32'(bus.rx_data);
        assign wc_v[g]    = 16'(bus.word_cnt);
    end

    always @(posedge clk) begin
        for (int j = 0; j < NI; j++) begin
            if (rxv_v[j]) rxv_cnt[j] <= rxv_cnt[j] + 1;
        end
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s inst=%0d actual=%h expected=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    function automatic logic [31:0] parity(input logic [31:0] w);
        return 32'($countones(w) % 2);
    endfunction

    // Reference: the returned stream is the received word read LSB first,
    // followed by its even-parity bit when that option is built in.
    function automatic logic [31:0] model_read(input int n, input logic [31:0] w);
        logic [31:0] r = 0;
        for (int i = 0; i < n; i++) r = r * 2 + ((w >> i) & 32'h1);
        if (PAR != 0) r = r * 2 + parity(w & mask(n));
        return r;
    endfunction

    function automatic logic [31:0] with_par(input logic [31:0] d, input logic [31:0] w);
        return (PAR != 0) ? (d * 2 + parity(w)) : d;
    endfunction

    task automatic spi_bits(input int k, input int n, input logic [31:0] dout, output logic [31:0] din);
        logic pol;
        pol = (cpol_of[k] != 0);
        din = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (cpha_of[k] == 0) begin
                mosi_v[k] = dout[i];
                repeat (HALF) @(negedge clk);
                sck_v[k] = ~pol;
                din = {din[30:0], miso_v[k]};
                repeat (HALF) @(negedge clk);
                sck_v[k] = pol;
            end else begin
                sck_v[k] = ~pol;
                mosi_v[k] = dout[i];
                repeat (HALF) @(negedge clk);
                sck_v[k] = pol;
                din = {din[30:0], miso_v[k]};
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic ss_low(input int k);
        ss_v[k] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_high(input int k);
        repeat (HALF) @(negedge clk);
        ss_v[k] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_word(input int k, input logic [31:0] w, input logic [31:0] exp_rd, input bit raise);
        logic [31:0] rx_miso, rd, wm;
        int n, p0;
        n  = width_of[k];
        wm = w & mask(n);
        p0 = rxv_cnt[k];
        if (ss_v[k]) ss_low(k);
        check("busy_in_rx", k, busy_v[k], 1);
        spi_bits(k, n, wm, rx_miso);
        check("miso_high_in_rx", k, rx_miso, mask(n));
        spi_bits(k, n + PAR, $urandom, rd);
        repeat (4) @(negedge clk);
        exp_cnt[k] = (exp_cnt[k] + 1) % cmod_of[k];
        check("tx_read", k, rd, exp_rd);
        check("rx_data", k, rxd_v[k], wm);
        check("rx_valid_pulses", k, rxv_cnt[k] - p0, 1);
        check("word_cnt", k, wc_v[k], exp_cnt[k]);
        check("abort_idle", k, abort_v[k], 0);
        if (raise) begin
            ss_high(k);
            check("busy_after_ss", k, busy_v[k], 0);
            check("miso_after_ss", k, miso_v[k], 1);
            check("abort_after_ss", k, abort_v[k], 0);
        end
    endtask

    initial begin
        vec_t tbl [11];
        logic [31:0] junk, w;
        int p0, c0, k;

        tbl[0]  = '{0, 32'h12,   32'h48,   1'b1};
        tbl[1]  = '{0, 32'h0F,   32'hF0,   1'b1};
        tbl[2]  = '{1, 32'h0F,   32'hF0,   1'b1};
        tbl[3]  = '{2, 32'h0F,   32'hF0,   1'b1};
        tbl[4]  = '{3, 32'h0F,   32'hF0,   1'b1};
        tbl[5]  = '{4, 32'h1234, 32'h2C48, 1'b0};
        tbl[6]  = '{4, 32'h8001, 32'h8001, 1'b1};
        tbl[7]  = '{0, 32'h01,   32'h80,   1'b1};
        tbl[8]  = '{2, 32'hA5,   32'hA5,   1'b1};
        tbl[9]  = '{1, 32'h80,   32'h01,   1'b1};
        tbl[10] = '{3, 32'h3A,   32'h5C,   1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_miso", i, miso_v[i], 1);
            check("rst_rx_valid", i, rxv_v[i], 0);
            check("rst_rx_data", i, rxd_v[i], 0);
            check("rst_word_cnt", i, wc_v[i], 0);
            check("rst_abort", i, abort_v[i], 0);
            check("rst_busy", i, busy_v[i], 0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            run_word(tbl[i].inst, tbl[i].word, with_par(tbl[i].exp_rd, tbl[i].word), tbl[i].raise);
        end

        // ss raised after 5 RX bits
        p0 = rxv_cnt[0];
        ss_low(0);
        spi_bits(0, 5, 32'h15, junk);
        ss_high(0);
        check("abort_rx_mid", 0, abort_v[0], 1);
        check("abort_rx_busy", 0, busy_v[0], 0);
        check("abort_rx_miso", 0, miso_v[0], 1);
        check("abort_rx_no_valid", 0, rxv_cnt[0] - p0, 0);
        check("abort_rx_word_cnt", 0, wc_v[0], exp_cnt[0]);
        ss_low(0);
        check("abort_cleared", 0, abort_v[0], 0);
        check("busy_after_fall", 0, busy_v[0], 1);
        run_word(0, 32'h12, with_par(32'h48, 32'h12), 1);

        // ss raised right after RX completes (TX phase, counter still 0)
        p0 = rxv_cnt[0];
        ss_low(0);
        spi_bits(0, 8, 32'h55, junk);
        ss_high(0);
        check("abort_tx0", 0, abort_v[0], 1);
        check("abort_tx0_valid", 0, rxv_cnt[0] - p0, 1);
        check("abort_tx0_rx_data", 0, rxd_v[0], 32'h55);
        check("abort_tx0_word_cnt", 0, wc_v[0], exp_cnt[0]);

        // Word counter wrap on the 2-bit counter instance
        for (int i = 0; i < 5; i++) begin
            w = $urandom & 32'hFF;
            run_word(3, w, model_read(8, w), (i == 4));
        end

        // Randomised words, modes and burst lengths
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, NI - 1);
            w = $urandom & mask(width_of[k]);
            run_word(k, w, model_read(width_of[k], w), ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < NI; i++) begin
            if (!ss_v[i]) ss_high(i);
        end

`ifdef SPI_BITREV_PARITY_EN
        // ss raised before the parity bit is sampled
        c0 = wc_v[0];
        ss_low(0);
        spi_bits(0, 8, 32'h13, junk);
        spi_bits(0, 8, 32'h00, junk);
        ss_high(0);
        check("abort_before_parity", 0, abort_v[0], 1);
        check("abort_parity_word_cnt", 0, wc_v[0], c0);
`endif

        // Asynchronous reset mid-TX
        ss_low(0);
        spi_bits(0, 8, 32'h12, junk);
        spi_bits(0, 3, 32'h0, junk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_miso", 0, miso_v[0], 1);
        check("async_rst_rx_valid", 0, rxv_v[0], 0);
        check("async_rst_rx_data", 0, rxd_v[0], 0);
        check("async_rst_word_cnt", 0, wc_v[0], 0);
        check("async_rst_abort", 0, abort_v[0], 0);
        check("async_rst_busy", 0, busy_v[0], 0);
        @(negedge clk);
        ss_v = '1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) exp_cnt[i] = 0;
        repeat (4) @(negedge clk);
        run_word(0, 32'h01, with_par(32'h80, 32'h01), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
